// File: rtl/amiga_clk_pkg.sv
// Shared constants for the Amiga chipset timing-enable generator.
package amiga_clk_pkg;

  localparam int unsigned DIV_28M   = 4;
  localparam int unsigned DIV_114M  = 16;
  localparam int unsigned E_DIV_PAL = 10;

  // Bits needed to hold values 0..v-1; callers guarantee v >= 2.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/amiga_clk_en_gen.sv
// Amiga chipset timing enables (7MHz, c1/c3, CCK, E phases) from one fast clock,
// with PLL-lock hold, 7MHz cycle stretch and E-clock resync.
module amiga_clk_en_gen
  import amiga_clk_pkg::*;
#(
  parameter int unsigned DIV   = DIV_28M,
  parameter int unsigned E_DIV = E_DIV_PAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             stall,
  input  logic             e_sync,
  output logic             clk7,
  output logic             clk7_en,
  output logic             clk7n_en,
  output logic             c1,
  output logic             c3,
  output logic             cck,
  output logic [E_DIV-1:0] eclk,
  output logic             e_en
);

  localparam int unsigned PHW = clog2(DIV);
  localparam int unsigned EW  = clog2(E_DIV);

  localparam logic [PHW-1:0] PH_LAST = PHW'(DIV - 1);
  localparam logic [PHW-1:0] PH_MID  = PHW'(DIV / 2 - 1);
  localparam logic [PHW-1:0] PH_HALF = PHW'(DIV / 2);
  localparam logic [PHW-1:0] PH_Q1   = PHW'(DIV / 4);
  localparam logic [PHW-1:0] PH_Q3   = PHW'(3 * DIV / 4);
  localparam logic [EW-1:0]  E_LAST  = EW'(E_DIV - 1);

  logic [PHW-1:0] ph;
  logic [EW-1:0]  e_cnt;
  logic           run;

  assign run = locked & ~rst;

  // Phase and E counters; both wrap by compare so non-power-of-two dividers work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph    <= '0;
      e_cnt <= '0;
    end else if (!locked) begin
      ph    <= '0;
      e_cnt <= '0;
    end else begin
      if (ph != PH_LAST) begin
        ph <= ph + PHW'(1);
      end else if (!stall) begin
        ph <= '0;
      end
      if (clk7_en) begin
        if (e_sync || (e_cnt == E_LAST)) begin
          e_cnt <= '0;
        end else begin
          e_cnt <= e_cnt + EW'(1);
        end
      end
    end
  end

  assign clk7_en  = run & (ph == PH_LAST) & ~stall;
  assign clk7n_en = run & (ph == PH_MID);
  assign clk7     = (ph < PH_HALF);
  assign c1       = clk7;
  assign c3       = (ph >= PH_Q1) & (ph < PH_Q3);
  assign cck      = ~e_cnt[0];
  assign e_en     = clk7_en & ((e_cnt == E_LAST) | e_sync);

  // One-hot E phase decode.
  always_comb begin
    eclk = '0;
    for (int unsigned i = 0; i < E_DIV; i++) begin
      eclk[i] = (e_cnt == EW'(i));
    end
  end

endmodule

// File: tb/tb_amiga_clk_en_gen.sv
// Self-checking bench: DIV=4 and DIV=16 generators against a cycle-position reference model.
module tb_amiga_clk_en_gen;
  import amiga_clk_pkg::*;

  logic clk, rst, locked, stall, e_sync;

  logic       a_clk7, a_clk7_en, a_clk7n_en, a_c1, a_c3, a_cck, a_e_en;
  logic [9:0] a_eclk;
  logic       b_clk7, b_clk7_en, b_clk7n_en, b_c1, b_c3, b_cck, b_e_en;
  logic [9:0] b_eclk;

  amiga_clk_en_gen #(.DIV(DIV_28M), .E_DIV(E_DIV_PAL)) dut_a (
    .clk(clk), .rst(rst), .locked(locked), .stall(stall), .e_sync(e_sync),
    .clk7(a_clk7), .clk7_en(a_clk7_en), .clk7n_en(a_clk7n_en), .c1(a_c1),
    .c3(a_c3), .cck(a_cck), .eclk(a_eclk), .e_en(a_e_en));

  amiga_clk_en_gen #(.DIV(DIV_114M), .E_DIV(E_DIV_PAL)) dut_b (
    .clk(clk), .rst(rst), .locked(locked), .stall(stall), .e_sync(e_sync),
    .clk7(b_clk7), .clk7_en(b_clk7_en), .clk7n_en(b_clk7n_en), .c1(b_c1),
    .c3(b_c3), .cck(b_cck), .eclk(b_eclk), .e_en(b_e_en));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: position within the 7MHz cycle and E period, as plain integers.
  int divs [2] = '{4, 16};
  int m_pos [2];
  int m_e [2];

  int step_no = 0;
  int b_last = 0;
  int b_period = 0;
  int a_en_cnt = 0;
  int a_een_cnt = 0;
  logic last_a_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic o_clk7, input logic o_c1, input logic o_c3,
                            input logic o_cck, input logic [9:0] o_eclk, input logic o_en,
                            input logic o_nen, input logic o_een);
    int d, p, e;
    logic run, x_en;
    d = divs[i];
    p = m_pos[i];
    e = m_e[i];
    run = locked && !rst;
    x_en = run && (p == d - 1) && !stall;
    chk($sformatf("i%0d_clk7 s%0d", i, step_no), 32'(o_clk7), 32'(p < d / 2));
    chk($sformatf("i%0d_c1 s%0d", i, step_no), 32'(o_c1), 32'(p < d / 2));
    chk($sformatf("i%0d_c3 s%0d", i, step_no), 32'(o_c3), 32'((p >= d / 4) && (p < 3 * d / 4)));
    chk($sformatf("i%0d_cck s%0d", i, step_no), 32'(o_cck), 32'((e % 2) == 0));
    chk($sformatf("i%0d_eclk s%0d", i, step_no), 32'(o_eclk), 32'(1) << e);
    chk($sformatf("i%0d_clk7_en s%0d", i, step_no), 32'(o_en), 32'(x_en));
    chk($sformatf("i%0d_clk7n_en s%0d", i, step_no), 32'(o_nen), 32'(run && (p == d / 2 - 1)));
    chk($sformatf("i%0d_e_en s%0d", i, step_no), 32'(o_een), 32'(x_en && ((e == 9) || e_sync)));
  endtask

  task automatic model_update(input logic l, input logic s, input logic es);
    for (int i = 0; i < 2; i++) begin
      if (!l) begin
        m_pos[i] = 0;
        m_e[i] = 0;
      end else begin
        if (m_pos[i] == divs[i] - 1 && !s) m_e[i] = es ? 0 : (m_e[i] + 1) % 10;
        if (m_pos[i] != divs[i] - 1) m_pos[i] = m_pos[i] + 1;
        else if (!s) m_pos[i] = 0;
      end
    end
  endtask

  // One fast clock cycle: apply inputs, check both instances, clock, advance model.
  task automatic drive(input logic l, input logic s, input logic es);
    locked = l;
    stall = s;
    e_sync = es;
    #1;
    check_inst(0, a_clk7, a_c1, a_c3, a_cck, a_eclk, a_clk7_en, a_clk7n_en, a_e_en);
    check_inst(1, b_clk7, b_c1, b_c3, b_cck, b_eclk, b_clk7_en, b_clk7n_en, b_e_en);
    last_a_en = a_clk7_en;
    if (a_clk7_en) a_en_cnt++;
    if (a_e_en) a_een_cnt++;
    if (b_clk7_en) begin
      b_period = step_no - b_last;
      b_last = step_no;
    end
    step_no++;
    @(posedge clk);
    model_update(l, s, es);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; locked = 1'b1; stall = 1'b0; e_sync = 1'b0;
    for (int i = 0; i < 2; i++) begin m_pos[i] = 0; m_e[i] = 0; end
    #3;
    chk("rst_clk7", 32'(a_clk7), 32'(1));
    chk("rst_c1", 32'(a_c1), 32'(1));
    chk("rst_c3", 32'(a_c3), 32'(0));
    chk("rst_cck", 32'(a_cck), 32'(1));
    chk("rst_eclk", 32'(a_eclk), 32'(1));
    chk("rst_en", 32'({a_clk7_en, a_clk7n_en, a_e_en, b_clk7_en, b_clk7n_en, b_e_en}), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Free run at DIV=4: 10 clk7_en and exactly one e_en per 40 fast cycles.
    a_en_cnt = 0; a_een_cnt = 0;
    for (int k = 0; k < 40; k++) drive(1'b1, 1'b0, 1'b0);
    chk("div4_en_per_40", 32'(a_en_cnt), 32'(10));
    chk("div4_e_en_per_40", 32'(a_een_cnt), 32'(1));
    for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, 1'b0);

    // Stretch the DIV=16 cycle by 5 at its last phase.
    n = 0;
    while (m_pos[1] != 15 && n < 40) begin drive(1'b1, 1'b0, 1'b0); n++; end
    chk("stall_reach_ph15", 32'(m_pos[1]), 32'(15));
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("stall_period_21", 32'(b_period), 32'(21));

    // E resync mid-period at e_cnt=4.
    n = 0;
    while (!(m_pos[0] == 3 && m_e[0] == 4) && n < 200) begin drive(1'b1, 1'b0, 1'b0); n++; end
    locked = 1'b1; stall = 1'b0; e_sync = 1'b1; #1;
    chk("esync4_e_en", 32'(a_e_en), 32'(1));
    drive(1'b1, 1'b0, 1'b1);
    chk("esync4_eclk0", 32'(a_eclk), 32'(1));

    // E resync exactly at the wrap point gives one pulse, next wrap a full period later.
    n = 0;
    while (!(m_pos[0] == 3 && m_e[0] == 9) && n < 200) begin drive(1'b1, 1'b0, 1'b0); n++; end
    a_een_cnt = 0;
    drive(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 36; k++) drive(1'b1, 1'b0, 1'b0);
    chk("esync9_single_e_en", 32'(a_een_cnt), 32'(1));

    // Lose PLL lock at ph=2, e_cnt=6, then relock.
    n = 0;
    while (!(m_pos[0] == 2 && m_e[0] == 6) && n < 200) begin drive(1'b1, 1'b0, 1'b0); n++; end
    drive(1'b0, 1'b0, 1'b0);
    chk("unlock_eclk", 32'(a_eclk), 32'(1));
    chk("unlock_clk7", 32'(a_clk7), 32'(1));
    chk("unlock_c3", 32'(a_c3), 32'(0));
    drive(1'b0, 1'b0, 1'b0);
    n = 0;
    last_a_en = 1'b0;
    while (!last_a_en && n < 20) begin drive(1'b1, 1'b0, 1'b0); n++; end
    chk("relock_first_en_cycles", 32'(n), 32'(4));

    // Randomised lock/stall/resync traffic.
    for (int k = 0; k < 400; k++) begin
      drive(logic'(($urandom % 16) != 0), logic'(($urandom % 4) == 0), logic'(($urandom % 8) == 0));
    end

    // Asynchronous reset mid-cycle, no clock edge in between.
    n = 0;
    while (m_pos[0] != 2 && n < 40) begin drive(1'b1, 1'b0, 1'b0); n++; end
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin m_pos[i] = 0; m_e[i] = 0; end
    chk("arst_clk7", 32'(a_clk7), 32'(1));
    chk("arst_c3", 32'(a_c3), 32'(0));
    chk("arst_eclk", 32'(a_eclk), 32'(1));
    chk("arst_b_cck", 32'(b_cck), 32'(1));
    check_inst(0, a_clk7, a_c1, a_c3, a_cck, a_eclk, a_clk7_en, a_clk7n_en, a_e_en);
    check_inst(1, b_clk7, b_c1, b_c3, b_cck, b_eclk, b_clk7_en, b_clk7n_en, b_e_en);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
